example_decoder: RTL and testbench
==================================

# example_decoder

Receive-side counterpart of the `Example` encoder: it consumes the encoded 32-bit code-word stream and reconstructs the header and data words. The block validates frame framing, removes the per-word key and, optionally, checks a trailing checksum. It sits at the receive end of the link and feeds the header/data consumers with registered valid-qualified outputs.

## Interface
- `WIDTH`, 32, code/header/data word width; only 32 is supported.
- `TIMEOUT`, 64, maximum idle cycles allowed inside a frame before the frame is aborted; range 2..65535.
- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_code_bus` in 32: encoded word.
- `i_code_valid` in 1: `i_code_bus` is valid this cycle; there is no backpressure.
- `o_header_bus` out 32: the accepted header word, passed unchanged.
- `o_header_valid` out 1: one-cycle pulse.
- `o_data_bus` out 32: decoded data word.
- `o_data_valid` out 1: one-cycle pulse per data word.
- `o_data_last` out 1: high with `o_data_valid` on the final data word of a frame.
- `o_sync_err` out 1: one-cycle pulse when a header is rejected.
- `o_chk_err` out 1: one-cycle pulse on a checksum mismatch.
- `o_timeout_err` out 1: one-cycle pulse when a frame is aborted on timeout.

## Operation
- Frame format: one header word, then LEN data words, then one checksum word (checksum word only when configured in).
- Header fields:
  - [31:24] sync marker, must equal 0xA5.
  - [23:16] LEN, 1..255.
  - [15:0] TAG.
- Decode rule: data word k (k = 0..LEN-1) is decoded as `o_data_bus = i_code_bus ^ ({TAG,TAG} ^ {24'h0,k[7:0]})`.
- Checksum word: the raw XOR of all decoded data words of the frame. It is not keyed.
- FSM states:
  - IDLE: a valid word is treated as a header.
    - Good marker and LEN≠0: latch TAG and LEN, pulse `o_header_valid`, clear the index and running XOR, go to DATA.
    - Otherwise: pulse `o_sync_err`, drop the word, stay in IDLE.
  - DATA: each valid word is decoded, emitted, and XORed into the running checksum; the index increments.
    - On index = LEN-1: assert `o_data_last`, then go to CHK if the checksum is configured in, else go to IDLE.
  - CHK: the next valid word is compared with the running XOR. On mismatch, pulse `o_chk_err`. Go to IDLE in either case.
- Cycles with `i_code_valid` low stall the FSM with no output.
- Timeout: in DATA or CHK, an idle counter increments every cycle with valid low and clears on valid high.
  - When the count reaches TIMEOUT: pulse `o_timeout_err` and go to IDLE.
  - The partial frame is abandoned; already-emitted words stand.
- The idle counter is held at 0 in IDLE.

## Timing
- All outputs are registered. Latency is 1 cycle from a valid input word to its output pulse.
- Back-to-back frames need no gap: a header may arrive in the cycle immediately after the last data word or the checksum word.
- Reset: all outputs are 0, FSM in IDLE, counters and running XOR cleared.
- Reset mid-frame drops the frame silently, with no error pulses.
- At most one of the valid/error pulses is asserted in any cycle, except `o_data_last`, which accompanies `o_data_valid`.
- TIMEOUT boundary: exactly TIMEOUT consecutive idle cycles trigger the abort; the pulse appears one cycle after the TIMEOUT-th idle cycle. TIMEOUT-1 idle cycles do not abort.
- LEN=255 wraps the index at 254→last with no overflow. The index width is 8 bits.

## Configuration
- `EXAMPLE_DEC_CHECKSUM_EN`:
  - Defined: the CHK state exists, the trailing checksum word is expected, and `o_chk_err` is live.
  - Undefined: frames end after the last data word, the running XOR and CHK logic are removed, and `o_chk_err` is tied to 0.

## Structure
- Package `example_codec_pkg` holds:
  - `SYNC_MARK` = 8'hA5.
  - The header struct (`sync`, `len`, `tag`).
  - The state enum (IDLE, DATA, CHK).
  - Function `key_word(tag, idx)`.
- The encoder should import the same package.
- Sub-module `example_dec_timeout`: an idle counter with inputs `clr`/`en` and output `expired`, parameterised by TIMEOUT.

## Test plan
- **Nominal frame.** Checksum enabled. Header 0xA5031234, codes 0xCC99ACDB, 0x12341234, 0x1234EDC9, checksum 0xDEAD4111, all back-to-back.
  - Expect `o_header_valid` with 0xA5031234.
  - Expect data 0xDEADBEEF, 0x00000001, 0x0000FFFF, with `o_data_last` on the third word.
  - Expect no errors.
- **Bad checksum.** Same frame with checksum 0xDEAD4110 → same data output, then one `o_chk_err` pulse, FSM back in IDLE.
- **Bad header.** 0x5A031234, then 0xA5001234 → two `o_sync_err` pulses, no `o_header_valid`. The following valid frame decodes correctly.
- **Timeout.** TIMEOUT=64. Header, one data word, then valid held low:
  - After 63 idle cycles: no error.
  - After 64 idle cycles: `o_timeout_err` pulse, FSM in IDLE.
  - A following frame decodes correctly.
- **Stalls and reset.** Nominal frame with valid-low gaps of 1–5 cycles → identical outputs. Assert `rst` mid-frame → all outputs 0, no error pulses, next frame OK.

Source files
------------

// File: rtl/example_codec_pkg.sv
// Shared types and keying helper for the Example encoder/decoder pair.
// Imported by example_decoder and example_dec_timeout users.
package example_codec_pkg;

  localparam logic [7:0] SYNC_MARK = 8'hA5;

  typedef struct packed {
    logic [7:0]  sync;
    logic [7:0]  len;
    logic [15:0] tag;
  } hdr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CHK  = 2'd2
  } dec_state_t;

  function automatic logic [31:0] key_word(
    input logic [15:0] tag,
    input logic [7:0]  idx
  );
    return {tag, tag} ^ {24'h0, idx};
  endfunction

endpackage

// File: rtl/example_dec_timeout.sv
// Idle-cycle watchdog for the decoder; expired flags the
// TIMEOUT-th consecutive enabled cycle.
module example_dec_timeout #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  assign expired = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr || expired) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/example_decoder.sv
// Receive-side decoder for the Example code-word stream.
// Optional trailing checksum: define EXAMPLE_DEC_CHECKSUM_EN.
module example_decoder #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_code_bus,
  input  logic             i_code_valid,
  output logic [WIDTH-1:0] o_header_bus,
  output logic             o_header_valid,
  output logic [WIDTH-1:0] o_data_bus,
  output logic             o_data_valid,
  output logic             o_data_last,
  output logic             o_sync_err,
  output logic             o_chk_err,
  output logic             o_timeout_err
);

  import example_codec_pkg::*;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_DATA = DATA;
  localparam logic [1:0] S_CHK  = CHK;

`ifdef EXAMPLE_DEC_CHECKSUM_EN
  localparam logic [1:0] S_END = S_CHK;
`else
  localparam logic [1:0] S_END = S_IDLE;
`endif

  logic [1:0]       state;
  logic [7:0]       len_q;
  logic [7:0]       idx_q;
  logic [15:0]      tag_q;
  hdr_t             hdr;
  logic             hdr_ok;
  logic             is_last;
  logic [WIDTH-1:0] dec_word;
  logic             tmo_clr;
  logic             tmo_en;
  logic             tmo_exp;

  assign hdr      = hdr_t'(i_code_bus);
  assign hdr_ok   = (hdr.sync == SYNC_MARK)
                 && (hdr.len != 8'd0);
  assign is_last  = (idx_q == len_q - 8'd1);
  assign dec_word = i_code_bus ^ key_word(tag_q, idx_q);
  assign tmo_clr  = (state == S_IDLE) || i_code_valid;
  assign tmo_en   = (state != S_IDLE) && !i_code_valid;

  example_dec_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expired(tmo_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      len_q          <= '0;
      idx_q          <= '0;
      tag_q          <= '0;
      o_header_bus   <= '0;
      o_header_valid <= 1'b0;
      o_data_bus     <= '0;
      o_data_valid   <= 1'b0;
      o_data_last    <= 1'b0;
      o_sync_err     <= 1'b0;
      o_timeout_err  <= 1'b0;
    end else begin
      o_header_valid <= 1'b0;
      o_data_valid   <= 1'b0;
      o_data_last    <= 1'b0;
      o_sync_err     <= 1'b0;
      o_timeout_err  <= 1'b0;
      unique case (1'b1)
        (state == S_IDLE): begin
          if (i_code_valid && hdr_ok) begin
            o_header_bus   <= i_code_bus;
            o_header_valid <= 1'b1;
            len_q          <= hdr.len;
            tag_q          <= hdr.tag;
            idx_q          <= '0;
            state          <= S_DATA;
          end else if (i_code_valid) begin
            o_sync_err <= 1'b1;
          end
        end
        (state == S_DATA): begin
          if (i_code_valid) begin
            o_data_bus   <= dec_word;
            o_data_valid <= 1'b1;
            o_data_last  <= is_last;
            idx_q        <= idx_q + 8'd1;
            if (is_last) state <= S_END;
          end else if (tmo_exp) begin
            o_timeout_err <= 1'b1;
            state         <= S_IDLE;
          end
        end
        (state == S_CHK): begin
          if (i_code_valid) begin
            state <= S_IDLE;
          end else if (tmo_exp) begin
            o_timeout_err <= 1'b1;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef EXAMPLE_DEC_CHECKSUM_EN
  logic [WIDTH-1:0] xor_q;
  logic             chk_err_q;

  // Running XOR restarts whenever the FSM sits in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      xor_q     <= '0;
      chk_err_q <= 1'b0;
    end else begin
      chk_err_q <= 1'b0;
      if (state == S_IDLE) begin
        xor_q <= '0;
      end else if (state == S_DATA && i_code_valid) begin
        xor_q <= xor_q ^ dec_word;
      end else if (state == S_CHK && i_code_valid) begin
        chk_err_q <= (i_code_bus != xor_q);
      end
    end
  end

  assign o_chk_err = chk_err_q;
`else
  assign o_chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_example_decoder.sv
// Scoreboard bench for example_decoder: directed frames,
// expected events queued by stimulus, checked by a monitor.
module tb_example_decoder;

  localparam int K_HDR  = 0;
  localparam int K_DAT  = 1;
  localparam int K_SYNC = 2;
  localparam int K_CHK  = 3;
  localparam int K_TMO  = 4;

  typedef struct {
    int          kind;
    logic [31:0] bus;
    logic        last;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_code_bus = '0;
  logic        i_code_valid = 1'b0;
  logic [31:0] o_header_bus;
  logic        o_header_valid;
  logic [31:0] o_data_bus;
  logic        o_data_valid;
  logic        o_data_last;
  logic        o_sync_err;
  logic        o_chk_err;
  logic        o_timeout_err;

  int  n_chk = 0;
  int  n_err = 0;
  ev_t exp_q[$];

  example_decoder #(
    .WIDTH  (32),
    .TIMEOUT(64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_code_bus    (i_code_bus),
    .i_code_valid  (i_code_valid),
    .o_header_bus  (o_header_bus),
    .o_header_valid(o_header_valid),
    .o_data_bus    (o_data_bus),
    .o_data_valid  (o_data_valid),
    .o_data_last   (o_data_last),
    .o_sync_err    (o_sync_err),
    .o_chk_err     (o_chk_err),
    .o_timeout_err (o_timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic push(int kind, logic [31:0] bus, logic last);
    ev_t e;
    e.kind = kind;
    e.bus  = bus;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic drive(logic v, logic [31:0] w);
    i_code_valid = v;
    i_code_bus   = w;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 32'h0);
  endtask

  // Monitor: pop one expected event per observed output pulse
  ev_t act_ev;
  ev_t exp_ev;
  int  n_pulse;

  always @(negedge clk) begin
    if (!rst) begin
      n_pulse = int'(o_header_valid) + int'(o_data_valid)
              + int'(o_sync_err) + int'(o_chk_err)
              + int'(o_timeout_err);
      if (o_data_last && !o_data_valid)
        check("last_wo_valid", 32'd1, 32'd0);
      if (n_pulse > 0) begin
        check("one_pulse", 32'(n_pulse), 32'd1);
        act_ev.bus  = 32'h0;
        act_ev.last = o_data_last;
        if (o_header_valid) begin
          act_ev.kind = K_HDR;
          act_ev.bus  = o_header_bus;
        end else if (o_data_valid) begin
          act_ev.kind = K_DAT;
          act_ev.bus  = o_data_bus;
        end else if (o_sync_err) begin
          act_ev.kind = K_SYNC;
        end else if (o_chk_err) begin
          act_ev.kind = K_CHK;
        end else begin
          act_ev.kind = K_TMO;
        end
        if (exp_q.size() == 0) begin
          check("unexpected_kind", 32'(act_ev.kind), 32'hFFFF);
        end else begin
          exp_ev = exp_q.pop_front();
          check("ev_kind", 32'(act_ev.kind), 32'(exp_ev.kind));
          check("ev_bus", act_ev.bus, exp_ev.bus);
          check("ev_last", 32'(act_ev.last), 32'(exp_ev.last));
        end
      end
    end
  end

  // Nominal 3-word frame; gap>0 inserts 1..5 idle cycles
  task automatic nominal(int gap, bit bad_chk);
    logic [31:0] codes [3];
    logic [31:0] datas [3];
    codes = '{32'hCC99ACDB, 32'h12341234, 32'h1234EDC9};
    datas = '{32'hDEADBEEF, 32'h00000001, 32'h0000FFFF};
    push(K_HDR, 32'hA5031234, 1'b0);
    drive(1'b1, 32'hA5031234);
    for (int i = 0; i < 3; i++) begin
      if (gap > 0) idle((i % 5) + 1);
      push(K_DAT, datas[i], i == 2);
      drive(1'b1, codes[i]);
    end
`ifdef EXAMPLE_DEC_CHECKSUM_EN
    if (gap > 0) idle(4);
    if (bad_chk) push(K_CHK, 32'h0, 1'b0);
    drive(1'b1, bad_chk ? 32'hDEAD4110 : 32'hDEAD4111);
`else
    if (bad_chk) drive(1'b0, 32'h0);
`endif
  endtask

  initial begin
    idle(2);
    check("rst_hdr_bus", o_header_bus, 32'h0);
    check("rst_hdr_v", 32'(o_header_valid), 32'd0);
    check("rst_dat_bus", o_data_bus, 32'h0);
    check("rst_dat_v", 32'(o_data_valid), 32'd0);
    check("rst_last", 32'(o_data_last), 32'd0);
    check("rst_sync", 32'(o_sync_err), 32'd0);
    check("rst_chk", 32'(o_chk_err), 32'd0);
    check("rst_tmo", 32'(o_timeout_err), 32'd0);
    rst = 1'b0;
    idle(1);

    nominal(0, 1'b0);
    nominal(0, 1'b1);

    push(K_SYNC, 32'h0, 1'b0);
    drive(1'b1, 32'h5A031234);
    push(K_SYNC, 32'h0, 1'b0);
    drive(1'b1, 32'hA5001234);
    nominal(0, 1'b0);

    // LEN=1 frame: single word is also the last
    push(K_HDR, 32'hA5011234, 1'b0);
    drive(1'b1, 32'hA5011234);
    push(K_DAT, 32'h00000000, 1'b1);
    drive(1'b1, 32'h12341234);
`ifdef EXAMPLE_DEC_CHECKSUM_EN
    drive(1'b1, 32'h00000000);
`endif

    push(K_HDR, 32'hA5031234, 1'b0);
    drive(1'b1, 32'hA5031234);
    push(K_DAT, 32'hDEADBEEF, 1'b0);
    drive(1'b1, 32'hCC99ACDB);
    push(K_TMO, 32'h0, 1'b0);
    idle(63);
    check("tmo_at_63", 32'(o_timeout_err), 32'd0);
    idle(1);
    check("tmo_at_64", 32'(o_timeout_err), 32'd1);
    nominal(0, 1'b0);

    nominal(5, 1'b0);

    push(K_HDR, 32'hA5031234, 1'b0);
    drive(1'b1, 32'hA5031234);
    push(K_DAT, 32'hDEADBEEF, 1'b0);
    drive(1'b1, 32'hCC99ACDB);
    idle(1);
    rst = 1'b1;
    drive(1'b1, 32'h12341234);
    drive(1'b1, 32'h1234EDC9);
    check("mid_rst_dat_v", 32'(o_data_valid), 32'd0);
    check("mid_rst_dat_bus", o_data_bus, 32'h0);
    check("mid_rst_hdr_bus", o_header_bus, 32'h0);
    check("mid_rst_errs",
          {29'h0, o_sync_err, o_chk_err, o_timeout_err}, 32'h0);
    rst = 1'b0;
    idle(1);
    nominal(0, 1'b0);

    idle(5);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
